// File: rtl/axi4_lite_bias_loader.sv
// rtl/axi4_lite_bias_loader.sv - AXI4-Lite master that writes (and optionally verifies) a bank of bias words
module axi4_lite_bias_loader #(
    parameter int                NUM_BIAS  = 20,
    parameter int                ADDR_W    = 7,
    parameter logic [ADDR_W-1:0] BASE_ADDR = '0,
    parameter bit                VERIFY    = 1'b1
) (
    input  logic                     CLK,
    input  logic                     RST,
    input  logic                     start,
    input  logic [32*NUM_BIAS-1:0]   bias_in,
    output logic                     busy,
    output logic                     done,
    output logic                     error,
    output logic [4:0]               err_index,
    output logic [ADDR_W-1:0]        m_axil_awaddr,
    output logic [2:0]               m_axil_awprot,
    output logic                     m_axil_awvalid,
    input  logic                     m_axil_awready,
    output logic [31:0]              m_axil_wdata,
    output logic [3:0]               m_axil_wstrb,
    output logic                     m_axil_wvalid,
    input  logic                     m_axil_wready,
    input  logic [1:0]               m_axil_bresp,
    input  logic                     m_axil_bvalid,
    output logic                     m_axil_bready,
    output logic [ADDR_W-1:0]        m_axil_araddr,
    output logic [2:0]               m_axil_arprot,
    output logic                     m_axil_arvalid,
    input  logic                     m_axil_arready,
    input  logic [31:0]              m_axil_rdata,
    input  logic [1:0]               m_axil_rresp,
    input  logic                     m_axil_rvalid,
    output logic                     m_axil_rready
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_WADDR,
        S_WRESP,
        S_RADDR,
        S_RDATA,
        S_DONE
    } state_t;

    localparam logic [4:0] LAST = 5'(NUM_BIAS - 1);

    state_t              state_q, state_d;
    logic [4:0]          index_q, index_d;
    logic [31:0]         words_q [32];
    logic [31:0]         words_d [32];
    logic                awvalid_q, awvalid_d;
    logic                wvalid_q, wvalid_d;
    logic [ADDR_W-1:0]   awaddr_q, awaddr_d;
    logic [31:0]         wdata_q, wdata_d;
    logic                bready_q, bready_d;
    logic                arvalid_q, arvalid_d;
    logic [ADDR_W-1:0]   araddr_q, araddr_d;
    logic                rready_q, rready_d;
    logic                busy_q, busy_d;
    logic                done_q, done_d;
    logic                error_q, error_d;
    logic [4:0]          err_index_q, err_index_d;
    logic                fail;
    logic                adv;

    // Word address wraps modulo 2^ADDR_W.
    function automatic logic [ADDR_W-1:0] word_addr(input logic [4:0] idx);
        return BASE_ADDR + ADDR_W'({idx, 2'b00});
    endfunction

    always_comb begin
        state_d     = state_q;
        index_d     = index_q;
        words_d     = words_q;
        awvalid_d   = awvalid_q;
        wvalid_d    = wvalid_q;
        awaddr_d    = awaddr_q;
        wdata_d     = wdata_q;
        bready_d    = bready_q;
        arvalid_d   = arvalid_q;
        araddr_d    = araddr_q;
        rready_d    = rready_q;
        busy_d      = busy_q;
        done_d      = 1'b0;
        error_d     = error_q;
        err_index_d = err_index_q;
        fail        = 1'b0;
        adv         = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (start) begin
                    for (int i = 0; i < NUM_BIAS; i++) begin
                        words_d[i] = bias_in[32*i +: 32];
                    end
                    index_d     = 5'd0;
                    busy_d      = 1'b1;
                    error_d     = 1'b0;
                    err_index_d = 5'd0;
                    awvalid_d   = 1'b1;
                    wvalid_d    = 1'b1;
                    awaddr_d    = word_addr(5'd0);
                    wdata_d     = bias_in[31:0];
                    state_d     = S_WADDR;
                end
            end
            S_WADDR: begin
                if (awvalid_q && m_axil_awready) begin
                    awvalid_d = 1'b0;
                end
                if (wvalid_q && m_axil_wready) begin
                    wvalid_d = 1'b0;
                end
                if ((!awvalid_q || m_axil_awready) && (!wvalid_q || m_axil_wready)) begin
                    bready_d = 1'b1;
                    state_d  = S_WRESP;
                end
            end
            S_WRESP: begin
                if (m_axil_bvalid) begin
                    bready_d = 1'b0;
                    fail     = (m_axil_bresp != 2'b00);
                    if (VERIFY) begin
                        arvalid_d = 1'b1;
                        araddr_d  = word_addr(index_q);
                        state_d   = S_RADDR;
                    end else begin
                        adv = 1'b1;
                    end
                end
            end
            S_RADDR: begin
                if (m_axil_arready) begin
                    arvalid_d = 1'b0;
                    rready_d  = 1'b1;
                    state_d   = S_RDATA;
                end
            end
            S_RDATA: begin
                if (m_axil_rvalid) begin
                    rready_d = 1'b0;
                    fail     = (m_axil_rresp != 2'b00) || (m_axil_rdata != words_q[index_q]);
                    adv      = 1'b1;
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        // Only the first failure of a run is recorded.
        if (fail && !error_q) begin
            error_d     = 1'b1;
            err_index_d = index_q;
        end

        if (adv) begin
            if (index_q == LAST) begin
                state_d = S_DONE;
                done_d  = 1'b1;
                busy_d  = 1'b0;
            end else begin
                index_d   = index_q + 5'd1;
                awvalid_d = 1'b1;
                wvalid_d  = 1'b1;
                awaddr_d  = word_addr(index_q + 5'd1);
                wdata_d   = words_q[index_q + 5'd1];
                state_d   = S_WADDR;
            end
        end
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state_q     <= S_IDLE;
            index_q     <= 5'd0;
            for (int i = 0; i < 32; i++) begin
                words_q[i] <= 32'd0;
            end
            awvalid_q   <= 1'b0;
            wvalid_q    <= 1'b0;
            awaddr_q    <= '0;
            wdata_q     <= 32'd0;
            bready_q    <= 1'b0;
            arvalid_q   <= 1'b0;
            araddr_q    <= '0;
            rready_q    <= 1'b0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            error_q     <= 1'b0;
            err_index_q <= 5'd0;
        end else begin
            state_q     <= state_d;
            index_q     <= index_d;
            words_q     <= words_d;
            awvalid_q   <= awvalid_d;
            wvalid_q    <= wvalid_d;
            awaddr_q    <= awaddr_d;
            wdata_q     <= wdata_d;
            bready_q    <= bready_d;
            arvalid_q   <= arvalid_d;
            araddr_q    <= araddr_d;
            rready_q    <= rready_d;
            busy_q      <= busy_d;
            done_q      <= done_d;
            error_q     <= error_d;
            err_index_q <= err_index_d;
        end
    end

    assign busy           = busy_q;
    assign done           = done_q;
    assign error          = error_q;
    assign err_index      = err_index_q;
    assign m_axil_awaddr  = awaddr_q;
    assign m_axil_awprot  = 3'b000;
    assign m_axil_awvalid = awvalid_q;
    assign m_axil_wdata   = wdata_q;
    assign m_axil_wstrb   = 4'b1111;
    assign m_axil_wvalid  = wvalid_q;
    assign m_axil_bready  = bready_q;
    assign m_axil_araddr  = araddr_q;
    assign m_axil_arprot  = 3'b000;
    assign m_axil_arvalid = arvalid_q;
    assign m_axil_rready  = rready_q;

endmodule

// File: tb/tb_axi4_lite_bias_loader.sv
// tb/tb_axi4_lite_bias_loader.sv - directed bench with an AXI4-Lite slave model for the bias loader
module tb_axi4_lite_bias_loader;

    localparam int NB = 20;
    localparam int AW = 7;

    logic              CLK = 1'b0;
    logic              RST;
    logic              start;
    logic [32*NB-1:0]  bias_in;
    logic              busy, done, error;
    logic [4:0]        err_index;
    logic [AW-1:0]     awaddr, araddr;
    logic [2:0]        awprot, arprot;
    logic              awvalid, awready, wvalid, wready, bvalid, bready;
    logic              arvalid, arready, rvalid, rready;
    logic [31:0]       wdata, rdata;
    logic [3:0]        wstrb;
    logic [1:0]        bresp, rresp;

    always #5 CLK = ~CLK;

    axi4_lite_bias_loader #(
        .NUM_BIAS(NB), .ADDR_W(AW), .BASE_ADDR(7'h00), .VERIFY(1'b1)
    ) dut (
        .CLK(CLK), .RST(RST), .start(start), .bias_in(bias_in),
        .busy(busy), .done(done), .error(error), .err_index(err_index),
        .m_axil_awaddr(awaddr), .m_axil_awprot(awprot), .m_axil_awvalid(awvalid),
        .m_axil_awready(awready), .m_axil_wdata(wdata), .m_axil_wstrb(wstrb),
        .m_axil_wvalid(wvalid), .m_axil_wready(wready), .m_axil_bresp(bresp),
        .m_axil_bvalid(bvalid), .m_axil_bready(bready), .m_axil_araddr(araddr),
        .m_axil_arprot(arprot), .m_axil_arvalid(arvalid), .m_axil_arready(arready),
        .m_axil_rdata(rdata), .m_axil_rresp(rresp), .m_axil_rvalid(rvalid),
        .m_axil_rready(rready)
    );

    int n_cmp = 0;
    int n_bad = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Slave model configuration and observation
    bit            rand_mode = 1'b0;
    int            b_extra = 0;
    int            slverr_idx = -1;
    logic [31:0]   corrupt_mask = 32'd0;
    logic [31:0]   mem [32];
    logic [AW-1:0] wr_addr_log [$];
    logic [31:0]   wr_data_log [$];
    int            rd_n = 0;
    int            done_cnt = 0;

    function automatic int pick();
        return rand_mode ? int'($urandom_range(0, 5)) : 0;
    endfunction

    initial begin
        bit            aw_hs, w_hs, b_hs, ar_hs, r_hs;
        bit            aw_pend, w_pend, ar_pend;
        bit            have_aw, have_w, have_ar, b_sched;
        logic [AW-1:0] hs_awaddr, hs_araddr, p_awaddr, p_araddr;
        logic [31:0]   hs_wdata, p_wdata;
        int            aw_dly, w_dly, b_dly, ar_dly, r_dly;
        int            aw_wait, w_wait, b_wait, ar_wait, r_wait;
        int            widx, ridx;
        awready = 0; wready = 0; bvalid = 0; bresp = 0;
        arready = 0; rvalid = 0; rdata = 0; rresp = 0;
        aw_hs = 0; w_hs = 0; b_hs = 0; ar_hs = 0; r_hs = 0;
        aw_pend = 0; w_pend = 0; ar_pend = 0;
        have_aw = 0; have_w = 0; have_ar = 0; b_sched = 0;
        hs_awaddr = 0; hs_araddr = 0; p_awaddr = 0; p_araddr = 0; hs_wdata = 0; p_wdata = 0;
        aw_dly = 0; w_dly = 0; b_dly = 0; ar_dly = 0; r_dly = 0;
        aw_wait = 0; w_wait = 0; b_wait = 0; ar_wait = 0; r_wait = 0;
        widx = 0; ridx = 0;
        for (int i = 0; i < 32; i++) mem[i] = 32'd0;
        forever begin
            @(negedge CLK);
            if (RST) begin
                awready = 0; wready = 0; bvalid = 0; bresp = 0;
                arready = 0; rvalid = 0; rdata = 0; rresp = 0;
                aw_hs = 0; w_hs = 0; b_hs = 0; ar_hs = 0; r_hs = 0;
                aw_pend = 0; w_pend = 0; ar_pend = 0;
                have_aw = 0; have_w = 0; have_ar = 0; b_sched = 0;
                aw_wait = 0; w_wait = 0; b_wait = 0; ar_wait = 0; r_wait = 0;
                continue;
            end
            if (aw_pend) check("aw_stable", {awvalid, awaddr}, {1'b1, p_awaddr});
            if (w_pend)  check("w_stable", {wvalid, wdata}, {1'b1, p_wdata});
            if (ar_pend) check("ar_stable", {arvalid, araddr}, {1'b1, p_araddr});
            if (done) done_cnt++;
            if (aw_hs) begin awready = 0; have_aw = 1; aw_dly = pick(); aw_wait = 0; end
            if (w_hs)  begin wready = 0; have_w = 1; w_dly = pick(); w_wait = 0; end
            if (b_hs)  begin bvalid = 0; bresp = 0; end
            if (ar_hs) begin arready = 0; have_ar = 1; ar_dly = pick(); ar_wait = 0; r_dly = pick(); r_wait = 0; end
            if (r_hs)  begin rvalid = 0; rd_n++; end
            if (awvalid && !awready) begin
                if (aw_wait >= aw_dly) awready = 1; else aw_wait++;
            end
            if (wvalid && !wready) begin
                if (w_wait >= w_dly) wready = 1; else w_wait++;
            end
            if (have_aw && have_w) begin
                widx = int'(hs_awaddr >> 2);
                mem[widx] = hs_wdata;
                wr_addr_log.push_back(hs_awaddr);
                wr_data_log.push_back(hs_wdata);
                have_aw = 0; have_w = 0;
                b_sched = 1; b_wait = 0; b_dly = pick() + b_extra;
            end
            if (b_sched) begin
                if (b_wait >= b_dly) begin
                    bvalid = 1;
                    bresp = (widx == slverr_idx) ? 2'b10 : 2'b00;
                    b_sched = 0;
                end else b_wait++;
            end
            if (arvalid && !arready) begin
                if (ar_wait == 0) check("ar_after_b", {b_sched, bvalid}, 2'b00);
                if (ar_wait >= ar_dly) arready = 1; else ar_wait++;
            end
            if (have_ar) begin
                if (r_wait >= r_dly) begin
                    ridx = int'(hs_araddr >> 2);
                    rvalid = 1;
                    rdata = mem[ridx] ^ (corrupt_mask[ridx] ? 32'h1 : 32'h0);
                    rresp = 2'b00;
                    have_ar = 0;
                end else r_wait++;
            end
            aw_hs = awvalid && awready;
            w_hs  = wvalid && wready;
            b_hs  = bvalid && bready;
            ar_hs = arvalid && arready;
            r_hs  = rvalid && rready;
            if (aw_hs) hs_awaddr = awaddr;
            if (w_hs)  hs_wdata = wdata;
            if (ar_hs) hs_araddr = araddr;
            aw_pend = awvalid && !awready; p_awaddr = awaddr;
            w_pend  = wvalid && !wready;   p_wdata = wdata;
            ar_pend = arvalid && !arready; p_araddr = araddr;
        end
    end

    typedef struct {
        bit          rnd;
        int          slverr;
        logic [31:0] corrupt;
        bit          mid_start;
        logic [31:0] wbase;
        bit          exp_err;
        logic [4:0]  exp_idx;
    } vec_t;

    vec_t        tbl [6];
    logic [31:0] exp_w [NB];

    task automatic check_idle_outputs(input string tag);
        check({tag, "_ctl"}, {awvalid, wvalid, bready, arvalid, rready, busy, done, error}, 8'h00);
        check({tag, "_eidx"}, err_index, 5'd0);
        check({tag, "_pay"}, {awaddr, wdata, araddr}, 0);
        check({tag, "_const"}, {awprot, arprot, wstrb}, {3'b000, 3'b000, 4'b1111});
    endtask

    task automatic run_scn(input vec_t v, input string tag);
        int cyc;
        rand_mode = v.rnd; slverr_idx = v.slverr; corrupt_mask = v.corrupt; b_extra = 0;
        wr_addr_log.delete(); wr_data_log.delete(); rd_n = 0; done_cnt = 0;
        for (int i = 0; i < NB; i++) begin
            exp_w[i] = v.wbase + 32'(i);
            bias_in[32*i +: 32] = exp_w[i];
        end
        start = 1;
        @(negedge CLK);
        start = 0;
        check({tag, "_first"}, {busy, awvalid, wvalid, awaddr, wdata}, {3'b111, 7'h00, exp_w[0]});
        cyc = 0;
        while (!done && cyc < 4000) begin
            @(negedge CLK);
            if (v.mid_start && cyc == 30) begin
                start = 1;
                bias_in = ~bias_in;
            end else begin
                start = 0;
            end
            cyc++;
        end
        start = 0;
        check({tag, "_done_seen"}, done, 1'b1);
        check({tag, "_busy_at_done"}, busy, 1'b0);
        check({tag, "_err"}, {error, err_index}, {v.exp_err, v.exp_idx});
        repeat (12) @(negedge CLK);
        check({tag, "_done_pulses"}, done_cnt, 1);
        check({tag, "_held"}, {done, busy, error, err_index}, {2'b00, v.exp_err, v.exp_idx});
        check({tag, "_nwrites"}, wr_addr_log.size(), NB);
        check({tag, "_nreads"}, rd_n, NB);
        for (int i = 0; i < NB && i < wr_addr_log.size(); i++) begin
            check($sformatf("%s_wr%0d", tag, i), {wr_addr_log[i], wr_data_log[i]}, {7'(4 * i), exp_w[i]});
        end
    endtask

    initial begin
        int cyc;
        RST = 1; start = 0; bias_in = '0;
        tbl[0] = '{1'b0, -1, 32'h0,       1'b0, 32'h0000_0678, 1'b0, 5'd0};
        tbl[1] = '{1'b1, -1, 32'h0,       1'b0, 32'h0000_0678, 1'b0, 5'd0};
        tbl[2] = '{1'b0,  7, 32'h0,       1'b0, 32'h1000_0000, 1'b1, 5'd7};
        tbl[3] = '{1'b0, -1, 32'h0000_1008, 1'b0, 32'hDEAD_0000, 1'b1, 5'd3};
        tbl[4] = '{1'b1, -1, 32'h0,       1'b1, 32'h5A5A_0100, 1'b0, 5'd0};
        tbl[5] = '{1'b1, 15, 32'h0000_0200, 1'b0, 32'h0BAD_F00D, 1'b1, 5'd9};
        repeat (3) @(negedge CLK);
        check_idle_outputs("reset");
        RST = 0;
        repeat (2) @(negedge CLK);
        check_idle_outputs("idle");

        for (int k = 0; k < 6; k++) begin
            run_scn(tbl[k], $sformatf("t%0d", k));
        end

        // Reset during the write response of word 5, then a clean rerun.
        rand_mode = 0; slverr_idx = -1; corrupt_mask = 0; b_extra = 5;
        wr_addr_log.delete(); wr_data_log.delete(); done_cnt = 0;
        for (int i = 0; i < NB; i++) bias_in[32*i +: 32] = 32'h7700_0000 + 32'(i);
        start = 1;
        @(negedge CLK);
        start = 0;
        cyc = 0;
        while (!(bready && wr_addr_log.size() == 6) && cyc < 2000) begin
            @(negedge CLK);
            cyc++;
        end
        check("rst_reach_wresp5", {bready, 8'(wr_addr_log.size())}, {1'b1, 8'd6});
        #2 RST = 1;
        #1 check_idle_outputs("rst_async");
        @(negedge CLK);
        @(negedge CLK);
        RST = 0;
        repeat (4) @(negedge CLK);
        check_idle_outputs("after_rst");
        check("rst_no_done", done_cnt, 0);
        run_scn(tbl[0], "rerun");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
